// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, register index type and
// the coarse instruction classes used by the issue stage.
package rv32_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef logic [4:0] reg_idx_t;

  // R: rs1+rs2 -> rd, I: rs1 -> rd, SB: rs1+rs2 no rd, U: no sources -> rd
  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_SB,
    CLS_U,
    CLS_ILLEGAL
  } instr_class_e;

  function automatic instr_class_e classify(input logic [6:0] opc);
    instr_class_e cls;
    case (opc)
      OPC_OP:                         cls = CLS_R;
      OPC_OPIMM, OPC_LOAD, OPC_JALR:  cls = CLS_I;
      OPC_STORE, OPC_BRANCH:          cls = CLS_SB;
      OPC_LUI, OPC_AUIPC, OPC_JAL:    cls = CLS_U;
      default:                        cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Bundle of fetch, register file, writeback and execute-side signals
// around the decode/issue stage.
interface decode_issue_if #(parameter int XLEN = 32) ();

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  rv32_pkg::reg_idx_t   rf_rs1;
  rv32_pkg::reg_idx_t   rf_rs2;
  logic [XLEN-1:0]      rf_rd1;
  logic [XLEN-1:0]      rf_rd2;
  logic                 wb_valid;
  rv32_pkg::reg_idx_t   wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic [XLEN-1:0]      out_op1;
  logic [XLEN-1:0]      out_op2;
  rv32_pkg::reg_idx_t   out_rd;
  logic                 out_we;
  logic                 out_illegal;

  // Environment side: fetch, register file, writeback and execute stage
  modport master (
    output flush, in_valid, in_instr, rf_rd1, rf_rd2,
           wb_valid, wb_rd, wb_data, out_ready,
    input  in_ready, rf_rs1, rf_rs2, out_valid, out_instr,
           out_op1, out_op2, out_rd, out_we, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, rf_rd1, rf_rd2,
           wb_valid, wb_rd, wb_data, out_ready,
    output in_ready, rf_rs1, rf_rs2, out_valid, out_instr,
           out_op1, out_op2, out_rd, out_we, out_illegal
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for destinations that have issued but not yet
// written back; x0 never becomes busy.
module reg_scoreboard
  import rv32_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_setEn,
  input  reg_idx_t        i_setIdx,
  input  logic            i_clrEn,
  input  reg_idx_t        i_clrIdx,
  input  logic            i_flushEn,
  input  reg_idx_t        i_flushIdx,
  output logic [NREG-1:0] o_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busyNext;

  // Set is applied last so a new producer survives its predecessor's writeback
  always_comb begin
    w_busyNext = r_busy;
    if (i_clrEn)   w_busyNext[i_clrIdx]   = 1'b0;
    if (i_flushEn) w_busyNext[i_flushIdx] = 1'b0;
    if (i_setEn)   w_busyNext[i_setIdx]   = 1'b1;
    w_busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busyNext;
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/decode_issue.sv
// Single-stage RV32I decode/issue: drives register file selects, stalls on
// RAW/WAW against the scoreboard and bypasses same-cycle writeback data.
module decode_issue
  import rv32_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  decode_issue_if.slave bus
);

  instr_class_e    w_class;
  reg_idx_t        w_rs1, w_rs2, w_rd;
  logic            w_usesRs1, w_usesRs2, w_writes;
  logic [NREG-1:0] w_busy;
  logic            w_clr1, w_clr2, w_clrRd;
  logic            w_hazard, w_accept;
  logic [XLEN-1:0] w_op1, w_op2;

  logic            r_outValid;
  logic [31:0]     r_outInstr;
  logic [XLEN-1:0] r_outOp1, r_outOp2;
  reg_idx_t        r_outRd;
  logic            r_outWe;
  logic            r_outIllegal;

  assign w_class   = classify(bus.in_instr[6:0]);
  assign w_rs1     = bus.in_instr[19:15];
  assign w_rs2     = bus.in_instr[24:20];
  assign w_rd      = bus.in_instr[11:7];
  assign w_usesRs1 = (w_class == CLS_R) || (w_class == CLS_I) || (w_class == CLS_SB);
  assign w_usesRs2 = (w_class == CLS_R) || (w_class == CLS_SB);
  assign w_writes  = ((w_class == CLS_R) || (w_class == CLS_I) || (w_class == CLS_U))
                     && (w_rd != 5'd0);

  assign bus.rf_rs1 = w_rs1;
  assign bus.rf_rs2 = w_rs2;

  // A register being written back this cycle no longer blocks issue
  assign w_clr1  = bus.wb_valid && (bus.wb_rd == w_rs1) && (w_rs1 != 5'd0);
  assign w_clr2  = bus.wb_valid && (bus.wb_rd == w_rs2) && (w_rs2 != 5'd0);
  assign w_clrRd = bus.wb_valid && (bus.wb_rd == w_rd)  && (w_rd  != 5'd0);

  assign w_hazard = (w_usesRs1 && (w_rs1 != 5'd0) && w_busy[w_rs1] && !w_clr1)
                 || (w_usesRs2 && (w_rs2 != 5'd0) && w_busy[w_rs2] && !w_clr2)
                 || (w_writes && w_busy[w_rd] && !w_clrRd);

  assign bus.in_ready = rst_n && (!r_outValid || bus.out_ready) && !w_hazard && !bus.flush;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // The register file write lands on the same edge, so rf_rd is stale here
  assign w_op1 = (!w_usesRs1 || (w_rs1 == 5'd0)) ? '0 : (w_clr1 ? bus.wb_data : bus.rf_rd1);
  assign w_op2 = (!w_usesRs2 || (w_rs2 == 5'd0)) ? '0 : (w_clr2 ? bus.wb_data : bus.rf_rd2);

  reg_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_setEn    (w_accept && w_writes),
    .i_setIdx   (w_rd),
    .i_clrEn    (bus.wb_valid),
    .i_clrIdx   (bus.wb_rd),
    .i_flushEn  (bus.flush && r_outValid && r_outWe),
    .i_flushIdx (r_outRd),
    .o_busy     (w_busy)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid   <= 1'b0;
      r_outInstr   <= '0;
      r_outOp1     <= '0;
      r_outOp2     <= '0;
      r_outRd      <= '0;
      r_outWe      <= 1'b0;
      r_outIllegal <= 1'b0;
    end else if (w_accept) begin
      r_outValid   <= 1'b1;
      r_outInstr   <= bus.in_instr;
      r_outOp1     <= w_op1;
      r_outOp2     <= w_op2;
      r_outRd      <= w_rd;
      r_outWe      <= w_writes;
      r_outIllegal <= (w_class == CLS_ILLEGAL);
    end else if (bus.flush || bus.out_ready) begin
      r_outValid   <= 1'b0;
    end
  end

  assign bus.out_valid   = r_outValid;
  assign bus.out_instr   = r_outInstr;
  assign bus.out_op1     = r_outOp1;
  assign bus.out_op2     = r_outOp2;
  assign bus.out_rd      = r_outRd;
  assign bus.out_we      = r_outWe;
  assign bus.out_illegal = r_outIllegal;

endmodule

// File: doc/decode_issue.md
# decode_issue

Single-stage RV32I decode/issue block that sits directly upstream of the register file. Accepts fetched instructions over a valid/ready handshake, extracts register fields, drives the register file read selects, and tracks in-flight destinations with a per-register scoreboard. Issues instructions with resolved operands to the execute stage, stalling on RAW and WAW hazards and bypassing same-cycle writeback data.

## Interface

Parameters:
- XLEN, 32, data width of operands and writeback data.
- NREG, 32, number of architectural registers; index width is clog2(NREG) = 5.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  discard the held output instruction.
- in_valid  in  1  in_instr is valid.
- in_ready  out  1  block accepts in_instr this cycle.
- in_instr  in  32  RV32I instruction word.
- rf_rs1, rf_rs2  out  5  register file read selects; combinational from in_instr.
- rf_rd1, rf_rd2  in  XLEN  register file read data for rf_rs1 and rf_rs2.
- wb_valid  in  1  a writeback occurs this cycle; the same wb_rd/wb_data also drive the register file write port.
- wb_rd  in  5  writeback destination.
- wb_data  in  XLEN  writeback data.
- out_valid  out  1  issued instruction valid.
- out_ready  in  1  execute stage accepts.
- out_instr  out  32  issued instruction word.
- out_op1, out_op2  out  XLEN  resolved source operands.
- out_rd  out  5  destination index.
- out_we  out  1  instruction writes out_rd (rd != 0).
- out_illegal  out  1  opcode not recognised.

## Operation

- Decode by opcode [6:0]:
  - R-type 0110011: uses rs1 and rs2; writes rd.
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111: uses rs1; writes rd.
  - STORE 0100011, BRANCH 1100011: uses rs1 and rs2; no write.
  - LUI 0110111, AUIPC 0010111, JAL 1101111: no sources; writes rd.
  - Any other opcode: no sources, no write; out_illegal = 1.
- Write enable: writes = class writes rd AND rd != 0.
- rf_rs1 = in_instr[19:15] and rf_rs2 = in_instr[24:20], always driven, regardless of class.
- Scoreboard: busy[NREG-1:0]; busy[0] is hardwired 0.
- clear(r) = wb_valid && wb_rd == r && r != 0.
- Hazard when any of the following holds:
  - the instruction uses rs1, rs1 != 0, busy[rs1], and not clear(rs1);
  - the same condition for rs2;
  - writes is set, busy[rd], and not clear(rd) (WAW).
- Handshakes:
  - in_ready = rst_n && (!out_valid || out_ready) && !hazard && !flush.
  - Accept when in_valid && in_ready.
- Operand resolution:
  - If the source index is 0 or the source is unused: operand = 0.
  - Else if clear(src): operand = wb_data, the bypass. The register file write lands at the same edge, so rf_rd is stale.
  - Else: operand = rf_rd.
- Busy update each cycle: busy_next = (busy & ~clear_mask) | set_mask.
  - set_mask has bit rd set on accept with writes = 1.
  - Set wins over clear on the same index. This occurs only when the bypass resolves a WAW.
- A writeback to a non-busy register clears nothing and is not an error.
- Flush:
  - out_valid is cleared next cycle even if out_ready = 1 this cycle; the issue is discarded.
  - If out_valid && out_we, busy[out_rd] is cleared.
  - No accept occurs in a flush cycle.
  - Instructions already accepted downstream are unaffected and still write back.

## Timing

- Reset (rst_n = 0 at an edge):
  - out_valid = 0; out_instr, out_op1, out_op2, out_rd = 0; out_we and out_illegal = 0; busy = 0.
  - in_ready is forced to 0 while rst_n = 0.
- Latency: accept at edge N gives out_valid = 1 after edge N, with all out_* registered.
- Output register behaviour:
  - Loads on accept.
  - Holds while out_valid && !out_ready.
  - Clears out_valid on out_ready without accept, or on flush.
- Throughput: one instruction per cycle when there are no hazards and out_ready is held at 1.
- A dependent back-to-back instruction stalls until the cycle its producer's wb_valid arrives. It issues in that cycle via the bypass.
- Reset mid-stall: all in-flight state is lost. Downstream must also be reset.

## Structure

- Shared package rv32_pkg:
  - opcode localparams (OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC);
  - typedef enum instr_class_e;
  - typedef reg_idx_t as logic [4:0].
- One sub-module: reg_scoreboard.
  - Holds busy bits.
  - Inputs: set index and enable, clear index and enable, flush-clear index and enable.
  - Outputs: busy vector.
- Decode, hazard, and bypass logic stays in decode_issue.

## Test plan

- Reset, then `addi x1,x0,5` (0x00500093) with out_ready = 1 → out_valid one cycle later, out_rd = 1, out_we = 1, out_op1 = 0; busy[1] = 1.
- `addi x1`, then `add x2,x1,x1`, with no writeback → in_ready = 0. Then drive wb_valid = 1, wb_rd = 1, wb_data = 7 → issue in that same cycle with out_op1 = out_op2 = 7, and busy[1] = 0 afterwards.
- WAW: x3 busy, then `lui x3` → stall. Drive wb_rd = 3 → issue the same cycle, and busy[3] remains 1.
- Hold out_ready = 0 with out_valid = 1 for 3 cycles → out_* stable and in_ready = 0. Release → the next instruction issues on the following cycle.
- flush while holding `addi x4` (unaccepted) → out_valid = 0 next cycle and busy[4] = 0. A subsequent `add x5,x4,x0` issues without stalling.
- Opcode 0x7F word → out_illegal = 1, out_we = 0, no busy bit set. `addi x0,x0,1` → out_we = 0, and busy stays all zero.
